// File: rtl/uart_pkg.sv
// uart_pkg: shared types, limits and divisor calculation for the UART baud-tick generator.
package uart_pkg;

    localparam int unsigned UART_DIV_W   = 16;
    localparam int unsigned UART_DIV_MIN = 2;

    typedef logic [UART_DIV_W-1:0] uart_div_t;

    // Rounded clk cycles per oversample tick: round(clk_mhz*1e6 / (baud*os)).
    function automatic int unsigned uart_calc_div(input int unsigned clk_mhz,
                                                  input int unsigned baud,
                                                  input int unsigned os);
        longint unsigned num;
        longint unsigned den;
        num = 64'(clk_mhz) * 64'd1000000;
        den = 64'(baud) * 64'(os);
        return 32'((num + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable oversample/bit tick generator for the UART TX/RX engines.
// Optional fractional divider enabled by defining UART_BAUD_FRAC_EN; the port list is
// the same either way (frac_value is simply ignored when the macro is undefined).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 44,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    input  logic [3:0]       frac_value,
    output logic [DIV_W-1:0] div_cur,
    output logic             tick_os,
    output logic             tick_baud
);

    localparam int unsigned DEF_DIV = uart_calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned OS_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    if (DEF_DIV < UART_DIV_MIN || 64'(DEF_DIV) >= (64'd1 << DIV_W)) begin : g_bad_div
        $error("uart_baud_gen: default divisor %0d out of range for DIV_W=%0d", DEF_DIV, DIV_W);
    end
    if (OVERSAMPLE < 2) begin : g_bad_os
        $error("uart_baud_gen: OVERSAMPLE must be >= 2");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic             tick_os_q, tick_os_d;
    logic             tick_baud_q, tick_baud_d;
    logic [DIV_W-1:0] load_div;
    logic [DIV_W:0]   period;
    logic             term;

    // Divisors below the minimum would make ticks back-to-back, so they are clamped.
    assign load_div = (div_value < DIV_W'(UART_DIV_MIN)) ? DIV_W'(UART_DIV_MIN) : div_value;

`ifdef UART_BAUD_FRAC_EN
    logic [3:0] frac_q, frac_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] acc_sum;
    logic       carry;

    // The period in progress is stretched by one cycle when this terminal count's
    // accumulation carries, so the mean period is div_reg + frac_reg/16.
    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, frac_q};
    assign period           = {1'b0, div_q} + (DIV_W + 1)'(carry);
`else
    logic unused_frac;
    assign unused_frac = ^frac_value;
    assign period      = {1'b0, div_q};
`endif

    assign term = ({1'b0, clk_cnt_q} == (period - (DIV_W + 1)'(1)));

    // Next divisor registers: only a load strobe changes them.
    always_comb begin
        div_d = div_q;
`ifdef UART_BAUD_FRAC_EN
        frac_d = frac_q;
`endif
        if (div_load) begin
            div_d = load_div;
`ifdef UART_BAUD_FRAC_EN
            frac_d = frac_value;
`endif
        end
    end

    // Next counter/tick state: load clears everything and wins over a terminal count.
    always_comb begin
        clk_cnt_d   = clk_cnt_q;
        os_cnt_d    = os_cnt_q;
        tick_os_d   = 1'b0;
        tick_baud_d = 1'b0;
`ifdef UART_BAUD_FRAC_EN
        acc_d = acc_q;
`endif
        if (div_load) begin
            clk_cnt_d = '0;
            os_cnt_d  = '0;
`ifdef UART_BAUD_FRAC_EN
            acc_d = '0;
`endif
        end else if (enable) begin
            if (term) begin
                clk_cnt_d = '0;
                tick_os_d = 1'b1;
`ifdef UART_BAUD_FRAC_EN
                acc_d = acc_sum;
`endif
                if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
                    os_cnt_d    = '0;
                    tick_baud_d = 1'b1;
                end else begin
                    os_cnt_d = os_cnt_q + OS_W'(1);
                end
            end else begin
                clk_cnt_d = clk_cnt_q + DIV_W'(1);
            end
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt_q   <= '0;
            os_cnt_q    <= '0;
            tick_os_q   <= 1'b0;
            tick_baud_q <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
            acc_q <= '0;
`endif
        end else begin
            clk_cnt_q   <= clk_cnt_d;
            os_cnt_q    <= os_cnt_d;
            tick_os_q   <= tick_os_d;
            tick_baud_q <= tick_baud_d;
`ifdef UART_BAUD_FRAC_EN
            acc_q <= acc_d;
`endif
        end
    end

    // Divisor registers, reset to the parameter-derived rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DIV_W'(DEF_DIV);
`ifdef UART_BAUD_FRAC_EN
            frac_q <= '0;
`endif
        end else begin
            div_q <= div_d;
`ifdef UART_BAUD_FRAC_EN
            frac_q <= frac_d;
`endif
        end
    end

    assign div_cur   = div_q;
    assign tick_os   = tick_os_q;
    assign tick_baud = tick_baud_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: table-driven divisor loads plus hand sequences for freeze,
// load-on-terminal, enable-low load, fractional rate and mid-count reset.
// Expected tick cycles are queued as stimulus is driven and popped by a tick monitor.
module tb_uart_baud_gen;

    localparam int DEF_P = 286;
    localparam int OS    = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        div_load;
    logic [15:0] div_value;
    logic [3:0]  frac_value;
    logic [15:0] div_cur;
    logic        tick_os;
    logic        tick_baud;

    uart_baud_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .div_load  (div_load),
        .div_value (div_value),
        .frac_value(frac_value),
        .div_cur   (div_cur),
        .tick_os   (tick_os),
        .tick_baud (tick_baud)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        bit baud;
    } exp_t;

    typedef struct {
        logic [15:0] div;
        int          exp_div;
        int          n;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[5];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input int c, input bit b);
        exp_t e;
        e.c    = c;
        e.baud = b;
        exp_q.push_back(e);
    endtask

    task automatic push_ticks(input int start, input int p, input int n);
        for (int k = 1; k <= n; k++) push(start + p * k, (k % OS) == 0);
    endtask

    task automatic drain(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic load(input int dv, input int fv);
        div_value  = 16'(dv);
        frac_value = 4'(fv);
        div_load   = 1'b1;
        step();
        div_load   = 1'b0;
    endtask

    // Tick monitor: every tick_os must match the oldest queued expectation.
    always @(negedge clk) begin
        if (tick_baud && !tick_os) check("baud_without_os", 1, 0);
        if (tick_os) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick_cycle", cyc, -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("tick_cycle", cyc, mon_e.c);
                check("tick_baud", int'(tick_baud), int'(mon_e.baud));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, L2, R, t, p;
        vecs[0].div = 16'd10; vecs[0].exp_div = 10; vecs[0].n = 32;
        vecs[1].div = 16'd0;  vecs[1].exp_div = 2;  vecs[1].n = 4;
        vecs[2].div = 16'd1;  vecs[2].exp_div = 2;  vecs[2].n = 4;
        vecs[3].div = 16'd3;  vecs[3].exp_div = 3;  vecs[3].n = 17;
        vecs[4].div = 16'd7;  vecs[4].exp_div = 7;  vecs[4].n = 3;

        rst_n = 1'b0; enable = 1'b0; div_load = 1'b0; div_value = '0; frac_value = '0;
        repeat (3) step();
        check("rst_tick_os", int'(tick_os), 0);
        check("rst_tick_baud", int'(tick_baud), 0);
        check("rst_div_cur", int'(div_cur), DEF_P);

        // Default rate from reset release.
        enable = 1'b1;
        rst_n  = 1'b1;
        R = cyc;
        push_ticks(R, DEF_P, OS);
        run_to(R + DEF_P * OS + 1);
        drain("default_missing_ticks");
        check("default_div_cur", int'(div_cur), DEF_P);

        // Divisor loads, including clamped values.
        for (int i = 0; i < 5; i++) begin
            L = cyc;
            load(int'(vecs[i].div), 0);
            check("vec_div_cur", int'(div_cur), vecs[i].exp_div);
            push_ticks(L + 1, vecs[i].exp_div, vecs[i].n);
            run_to(L + 1 + vecs[i].exp_div * vecs[i].n + 1);
            drain("vec_missing_ticks");
        end

        // Freeze for 7 cycles with 4 counts done; the remaining 6 counts finish after resume.
        L = cyc;
        load(10, 0);
        push(L + 18, 1'b0);
        push(L + 28, 1'b0);
        repeat (4) step();
        enable = 1'b0;
        repeat (7) step();
        enable = 1'b1;
        run_to(L + 29);
        drain("freeze_missing_ticks");

        // Load in a terminal-count cycle: that tick is dropped, new period starts.
        L = cyc;
        load(10, 0);
        push(L + 11, 1'b0);
        run_to(L + 20);
        L2 = cyc;
        load(5, 0);
        push_ticks(L2 + 1, 5, 2);
        run_to(L2 + 12);
        drain("term_load_missing_ticks");
        check("term_load_div_cur", int'(div_cur), 5);

        // Load while disabled takes effect; counting starts from zero on enable.
        enable = 1'b0;
        L = cyc;
        load(4, 0);
        check("dis_load_div_cur", int'(div_cur), 4);
        repeat (4) step();
        enable = 1'b1;
        push(L + 9, 1'b0);
        run_to(L + 10);
        drain("dis_load_missing_ticks");

        // Fractional divider: 10 + 8/16 alternates 10/11 (168 cycles per 16 ticks).
        L = cyc;
        load(10, 8);
        t = L + 1;
        for (int k = 1; k <= OS; k++) begin
`ifdef UART_BAUD_FRAC_EN
            p = (k % 2 == 1) ? 10 : 11;
`else
            p = 10;
`endif
            t = t + p;
            push(t, k == OS);
        end
        run_to(t + 1);
        drain("frac_missing_ticks");

        // Reset during a tick cycle clears outputs immediately.
        L = cyc;
        load(10, 0);
        push(L + 11, 1'b0);
        run_to(L + 11);
        @(negedge clk);
        #2;
        check("pre_rst_tick_os", int'(tick_os), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tick_os", int'(tick_os), 0);
        check("mid_rst_div_cur", int'(div_cur), DEF_P);
        repeat (3) step();
        rst_n = 1'b1;
        R = cyc;
        check("post_rst_div_cur", int'(div_cur), DEF_P);
        push(R + DEF_P, 1'b0);
        run_to(R + DEF_P + 1);
        drain("post_rst_missing_ticks");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
